uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
Parametrised multicycle control unit for the polirv RV64I core, replacing the single-cycle `uc` control.
- Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Drives the `fd` datapath enables and mux selects.
- Uses req/ack handshakes to instruction and data memory, with a configurable wait-state watchdog.
- Adds a 2-bit pc_src/rf_src that supports JAL/JALR/LUI, plus branch resolution from funct3 and ALU flags.

Parameters:
- ALU_CMD_BITS, 4, width of alu_cmd.
- WAIT_MAX, 15, max extra cycles a memory req may wait for ack; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  7  IR[6:0] from fd.
- funct3  in  3  IR[14:12] from fd.
- alu_flags  in  4  [0] zero, [1] MSB, [2] overflow, [3] carry (1 = no borrow on subtract).
- i_mem_req  out  1  instruction fetch request.
- i_mem_ack  in  1  instruction data valid this cycle.
- d_mem_req  out  1  data access request.
- d_mem_ack  in  1  data access complete this cycle.
- d_mem_we  out  1  data memory write (store).
- ir_we  out  1  load IR.
- pc_we  out  1  update PC.
- rf_we  out  1  register file write.
- alu_cmd  out  ALU_CMD_BITS  0000 R, 0001 I, 0010 S, 0011 SB, 0100 U, 0101 UJ.
- alu_src  out  1  0 rf, 1 imm.
- pc_src  out  2  00 +4, 01 +imm, 10 alu (JALR).
- rf_src  out  2  00 alu, 01 d_mem, 10 pc+4, 11 imm.
- busy  out  1  high in every state except RST/FAULT.
- fault  out  1  watchdog tripped; sticky until reset.

Behaviour:
- rst_n low at a clk edge: state to RST, watchdog counter to 0. In RST all outputs are 0 (alu_cmd 0, selects 00). RST always goes to FETCH next cycle.
- Reset applies mid-operation identically. An outstanding req drops the cycle after the reset edge.
- Outputs are Moore (state-decoded), except ir_we/pc_we/rf_we/d_mem_we, which are qualified by ack or branch result as stated per state.
- FETCH:
  - i_mem_req=1.
  - On i_mem_ack: ir_we=1 that cycle, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle; classifies opcode; next state EXEC.
- EXEC, by opcode:
  - R 0110011: alu_cmd R, alu_src 0; next WB.
  - I-ALU 0010011: alu_cmd I, alu_src 1; next WB.
  - LOAD 0000011: alu_cmd I, alu_src 1; next MEM.
  - STORE 0100011: alu_cmd S, alu_src 1; next MEM.
  - BRANCH 1100011:
    - alu_cmd SB, alu_src 0; pc_we=1.
    - pc_src=01 if taken, else 00; next FETCH.
  - LUI 0110111, JAL 1101111, JALR 1100111: alu_cmd U/UJ/I; next WB.
  - Any other opcode: pc_we=1, pc_src 00 (NOP); next FETCH.
- Branch taken rule (funct3 → condition):
  - 000: zero.
  - 001: !zero.
  - 100: MSB^ovf.
  - 101: !(MSB^ovf).
  - 110: !carry.
  - 111: carry.
  - 010/011: never taken.
- MEM:
  - d_mem_req=1 held until ack; d_mem_we=1 throughout for STORE. Address/data are held stable by the EXEC ALU result register in fd.
  - On ack, LOAD: next WB.
  - On ack, STORE: pc_we=1, pc_src 00; next FETCH.
- WB: rf_we=1, pc_we=1; next FETCH. Selects by opcode:
  - R/I: rf_src 00, pc_src 00.
  - LOAD: rf_src 01, pc_src 00.
  - LUI: rf_src 11, pc_src 00.
  - JAL: rf_src 10, pc_src 01.
  - JALR: rf_src 10, pc_src 10, alu_cmd I, alu_src 1.
- Latency with same-cycle ack:
  - BRANCH/NOP: 3 cycles.
  - R/I/LUI/JAL/JALR/STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Watchdog:
  - Counter clears on entering FETCH or MEM and increments each cycle req is high without ack.
  - Ack is accepted while counter ≤ WAIT_MAX.
  - If counter == WAIT_MAX and ack is 0: next state FAULT.
- FAULT: all outputs 0 except fault=1; exits only via reset. With WAIT_MAX=0 the watchdog is disabled and FAULT is unreachable (except via ILLEGAL_TRAP_EN).
- Simultaneous reset and ack: reset wins; no ir_we/pc_we/rf_we is issued.

Optional Feature:
- UC_ILLEGAL_TRAP_EN defined: an unknown opcode in EXEC goes to FAULT with fault=1 and no pc_we. Adds an output `illegal` (1 bit, sticky until reset, 0 at reset).
- Not defined: unknown opcode is executed as a NOP (PC+4); there is no `illegal` port.

Decomposition:
- polirv_pkg holds:
  - opcode constants;
  - state enum RST/FETCH/DECODE/EXEC/MEM/WB/FAULT;
  - alu_cmd encodings;
  - pc_src/rf_src encodings;
  - flag bit indices.
- Sub-module uc_branch_eval: combinational (funct3, alu_flags) → taken.
- Watchdog counter stays inline.

Test Plan:
- Reset held 3 cycles, release, i_mem_ack=1 every cycle, opcode 0110011: all outputs 0 in RST. Then i_mem_req then ir_we, with rf_we and pc_we (pc_src 00, rf_src 00) 4 cycles after FETCH entry.
- LOAD 0000011 with d_mem_ack delayed 3 cycles: d_mem_req high 4 cycles, d_mem_we=0, then WB with rf_src 01; total 8 cycles.
- BEQ with zero=1 → pc_we, pc_src 01 in cycle 3. BLTU with carry=1 → pc_src 00. BGE with MSB=1, ovf=1 → taken.
- JALR: WB shows rf_src 10, pc_src 10, alu_src 1. LUI: rf_src 11.
- WAIT_MAX=15, i_mem_ack never asserted: i_mem_req high 16 cycles, then fault=1, busy=0 until rst_n low, then RST then FETCH.
- Opcode 1111111: without UC_ILLEGAL_TRAP_EN → pc_we with pc_src 00 in cycle 3. With it → fault=1, illegal=1, no pc_we.

Source files
------------

// File: rtl/polirv_pkg.sv
// Shared encodings for the polirv RV64I multicycle control unit:
// opcodes, FSM states, decoded instruction classes, mux selects and ALU flag bits.
package polirv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    RST,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    FAULT
  } uc_state_e;

  typedef enum logic [3:0] {
    OP_R,
    OP_I,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_LUI,
    OP_JAL,
    OP_JALR,
    OP_ILLEGAL
  } op_class_e;

  localparam logic [3:0] ALU_R  = 4'b0000;
  localparam logic [3:0] ALU_I  = 4'b0001;
  localparam logic [3:0] ALU_S  = 4'b0010;
  localparam logic [3:0] ALU_SB = 4'b0011;
  localparam logic [3:0] ALU_U  = 4'b0100;
  localparam logic [3:0] ALU_UJ = 4'b0101;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] RF_ALU = 2'b00;
  localparam logic [1:0] RF_MEM = 2'b01;
  localparam logic [1:0] RF_PC4 = 2'b10;
  localparam logic [1:0] RF_IMM = 2'b11;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_MSB   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_R:      return OP_R;
      OPC_I:      return OP_I;
      OPC_LOAD:   return OP_LOAD;
      OPC_STORE:  return OP_STORE;
      OPC_BRANCH: return OP_BRANCH;
      OPC_LUI:    return OP_LUI;
      OPC_JAL:    return OP_JAL;
      OPC_JALR:   return OP_JALR;
      default:    return OP_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/uc_branch_eval.sv
// Branch resolution: maps funct3 and the ALU flags of the compare to taken/not-taken.
module uc_branch_eval
  import polirv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] alu_flags,
  output logic       taken
);

  logic zero;
  logic lt_signed;
  logic carry;

  assign zero      = alu_flags[FLAG_ZERO];
  assign lt_signed = alu_flags[FLAG_MSB] ^ alu_flags[FLAG_OVF];
  assign carry     = alu_flags[FLAG_CARRY];

  always_comb begin
    // NOTE: default before the case so every path assigns taken and no latch is inferred.
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt_signed;
      3'b101:  taken = !lt_signed;
      3'b110:  taken = !carry;
      3'b111:  taken = carry;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle Moore control unit for the polirv fd datapath with memory req/ack watchdog.
// Optional macro UC_ILLEGAL_TRAP_EN: unknown opcodes trap to FAULT and raise `illegal`.
module uc_multiciclo
  import polirv_pkg::*;
#(
  parameter int          ALU_CMD_BITS = 4,
  parameter int unsigned WAIT_MAX     = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [3:0]              alu_flags,
  output logic                    i_mem_req,
  input  logic                    i_mem_ack,
  output logic                    d_mem_req,
  input  logic                    d_mem_ack,
  output logic                    d_mem_we,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic                    rf_we,
  output logic [ALU_CMD_BITS-1:0] alu_cmd,
  output logic                    alu_src,
  output logic [1:0]              pc_src,
  output logic [1:0]              rf_src,
  output logic                    busy,
  output logic                    fault
`ifdef UC_ILLEGAL_TRAP_EN
  ,
  output logic                    illegal
`endif
);

  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam bit WD_EN = (WAIT_MAX != 0);

  uc_state_e        state;
  uc_state_e        state_next;
  op_class_e        op_class;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expire;
  logic             wd_count_en;
  logic             taken;
  logic             strobe_en;

  uc_branch_eval u_branch_eval (
    .funct3    (funct3),
    .alu_flags (alu_flags),
    .taken     (taken)
  );

  // A reset arriving together with an ack must not commit IR/PC/RF writes.
  assign strobe_en   = rst_n;
  assign wd_expire   = WD_EN && (wd_cnt == CNT_W'(WAIT_MAX));
  assign wd_count_en = WD_EN && ((i_mem_req && !i_mem_ack) || (d_mem_req && !d_mem_ack));

  always_comb begin
    state_next = state;
    i_mem_req  = 1'b0;
    d_mem_req  = 1'b0;
    d_mem_we   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    alu_cmd    = '0;
    alu_src    = 1'b0;
    pc_src     = PC_PLUS4;
    rf_src     = RF_ALU;
    busy       = (state != RST) && (state != FAULT);
    fault      = (state == FAULT);

    case (state)
      RST: state_next = FETCH;

      FETCH: begin
        i_mem_req = 1'b1;
        if (i_mem_ack) begin
          ir_we      = strobe_en;
          state_next = DECODE;
        end else if (wd_expire) begin
          state_next = FAULT;
        end
      end

      DECODE: state_next = EXEC;

      EXEC: begin
        case (op_class)
          OP_R: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_R);
            state_next = WB;
          end
          OP_I: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_I);
            alu_src    = 1'b1;
            state_next = WB;
          end
          OP_LOAD: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_I);
            alu_src    = 1'b1;
            state_next = MEM;
          end
          OP_STORE: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_S);
            alu_src    = 1'b1;
            state_next = MEM;
          end
          OP_BRANCH: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_SB);
            pc_we      = strobe_en;
            pc_src     = taken ? PC_IMM : PC_PLUS4;
            state_next = FETCH;
          end
          OP_LUI: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_U);
            alu_src    = 1'b1;
            state_next = WB;
          end
          OP_JAL: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_UJ);
            state_next = WB;
          end
          OP_JALR: begin
            alu_cmd    = ALU_CMD_BITS'(ALU_I);
            alu_src    = 1'b1;
            state_next = WB;
          end
          default: begin
`ifdef UC_ILLEGAL_TRAP_EN
            state_next = FAULT;
`else
            pc_we      = strobe_en;
            pc_src     = PC_PLUS4;
            state_next = FETCH;
`endif
          end
        endcase
      end

      MEM: begin
        d_mem_req = 1'b1;
        d_mem_we  = (op_class == OP_STORE);
        if (d_mem_ack) begin
          if (op_class == OP_STORE) begin
            pc_we      = strobe_en;
            pc_src     = PC_PLUS4;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (wd_expire) begin
          state_next = FAULT;
        end
      end

      WB: begin
        rf_we      = strobe_en;
        pc_we      = strobe_en;
        state_next = FETCH;
        case (op_class)
          OP_R: begin
            alu_cmd = ALU_CMD_BITS'(ALU_R);
          end
          OP_I: begin
            alu_cmd = ALU_CMD_BITS'(ALU_I);
            alu_src = 1'b1;
          end
          OP_LOAD: rf_src = RF_MEM;
          OP_LUI:  rf_src = RF_IMM;
          OP_JAL: begin
            rf_src = RF_PC4;
            pc_src = PC_IMM;
          end
          OP_JALR: begin
            rf_src  = RF_PC4;
            pc_src  = PC_ALU;
            alu_cmd = ALU_CMD_BITS'(ALU_I);
            alu_src = 1'b1;
          end
          default: rf_src = RF_ALU;
        endcase
      end

      FAULT: state_next = FAULT;

      default: state_next = RST;
    endcase
  end

  // Instruction class is latched in DECODE; IR is stable from then until the next fetch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state    <= RST;
      op_class <= OP_ILLEGAL;
      wd_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        op_class <= classify(opcode);
      end
      if ((state_next == FETCH || state_next == MEM) && (state_next != state)) begin
        wd_cnt <= '0;
      end else if (wd_count_en) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end

`ifdef UC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (state == EXEC && op_class == OP_ILLEGAL) begin
      illegal <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed self-checking bench for uc_multiciclo (WAIT_MAX=15, ALU_CMD_BITS=4).
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] alu_flags;
  logic       i_mem_req, i_mem_ack;
  logic       d_mem_req, d_mem_ack, d_mem_we;
  logic       ir_we, pc_we, rf_we;
  logic [3:0] alu_cmd;
  logic       alu_src;
  logic [1:0] pc_src, rf_src;
  logic       busy, fault;
`ifdef UC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks   = 0;
  int failures = 0;

  uc_multiciclo #(
    .ALU_CMD_BITS (4),
    .WAIT_MAX     (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .alu_flags (alu_flags),
    .i_mem_req (i_mem_req),
    .i_mem_ack (i_mem_ack),
    .d_mem_req (d_mem_req),
    .d_mem_ack (d_mem_ack),
    .d_mem_we  (d_mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .alu_cmd   (alu_cmd),
    .alu_src   (alu_src),
    .pc_src    (pc_src),
    .rf_src    (rf_src),
    .busy      (busy),
    .fault     (fault)
`ifdef UC_ILLEGAL_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // strb = {i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, rf_we}; selects only checked when written.
  task automatic chk_ctl(input string tag, input logic [5:0] strb, input logic [1:0] pcs,
                         input logic [1:0] rfs);
    check($sformatf("%s.strobes", tag),
          32'({i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, rf_we}), 32'(strb));
    check($sformatf("%s.busy_fault", tag), 32'({busy, fault}), 32'b10);
    if (strb[1]) check($sformatf("%s.pc_src", tag), 32'(pc_src), 32'(pcs));
    if (strb[0]) check($sformatf("%s.rf_src", tag), 32'(rf_src), 32'(rfs));
  endtask

  task automatic chk_alu(input string tag, input logic [3:0] cmd, input logic src);
    check($sformatf("%s.alu", tag), 32'({alu_cmd, alu_src}), 32'({cmd, src}));
  endtask

  // Everything zero except fault.
  task automatic chk_idle(input string tag, input logic flt);
    check(tag, 32'({i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, rf_we, alu_src, busy,
                    fault, pc_src, rf_src, alu_cmd}), 32'({8'b0, flt, 8'b0}));
  endtask

  task automatic fetch_decode(input string tag, input logic [6:0] op, input logic [2:0] f3);
    step();
    opcode = op;
    funct3 = f3;
    settle();
    chk_ctl($sformatf("%s.fetch", tag), 6'b100100, 2'b00, 2'b00);
    step();
    chk_ctl($sformatf("%s.decode", tag), 6'b000000, 2'b00, 2'b00);
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3, input logic [3:0] flags,
                            input logic [1:0] exp_pcs);
    alu_flags = flags;
    fetch_decode(tag, 7'b1100011, f3);
    step();
    chk_ctl($sformatf("%s.exec", tag), 6'b000010, exp_pcs, 2'b00);
    chk_alu($sformatf("%s.exec", tag), 4'b0011, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_mem_ack = 1'b1;
    d_mem_ack = 1'b0;
    opcode    = 7'b0110011;
    funct3    = 3'b000;
    alu_flags = 4'b0000;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("rst%0d", i), 1'b0);
    end
`ifdef UC_ILLEGAL_TRAP_EN
    check("rst.illegal", 32'(illegal), 32'd0);
`endif

    // R-type with same-cycle ack: WB four cycles after FETCH entry.
    rst_n = 1'b1;
    step();
    chk_ctl("r.fetch", 6'b100100, 2'b00, 2'b00);
    step();
    chk_ctl("r.decode", 6'b000000, 2'b00, 2'b00);
    step();
    chk_ctl("r.exec", 6'b000000, 2'b00, 2'b00);
    chk_alu("r.exec", 4'b0000, 1'b0);
    step();
    chk_ctl("r.wb", 6'b000011, 2'b00, 2'b00);

    // LOAD with data ack three cycles late: four MEM cycles, eight total.
    fetch_decode("ld", 7'b0000011, 3'b011);
    step();
    chk_ctl("ld.exec", 6'b000000, 2'b00, 2'b00);
    chk_alu("ld.exec", 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctl($sformatf("ld.mem_wait%0d", i), 6'b010000, 2'b00, 2'b00);
    end
    step();
    d_mem_ack = 1'b1;
    settle();
    chk_ctl("ld.mem_ack", 6'b010000, 2'b00, 2'b00);
    step();
    d_mem_ack = 1'b0;
    settle();
    chk_ctl("ld.wb", 6'b000011, 2'b00, 2'b01);

    // Branches; flags = {carry, ovf, msb, zero}.
    run_branch("beq_t",  3'b000, 4'b0001, 2'b01);
    run_branch("bne_nt", 3'b001, 4'b0001, 2'b00);
    run_branch("blt_t",  3'b100, 4'b0010, 2'b01);
    run_branch("bge_t",  3'b101, 4'b0110, 2'b01);
    run_branch("bltu_nt", 3'b110, 4'b1000, 2'b00);
    run_branch("bgeu_t", 3'b111, 4'b1000, 2'b01);
    run_branch("f3_010", 3'b010, 4'b1111, 2'b00);

    // JALR
    fetch_decode("jalr", 7'b1100111, 3'b000);
    step();
    chk_alu("jalr.exec", 4'b0001, 1'b1);
    step();
    chk_ctl("jalr.wb", 6'b000011, 2'b10, 2'b10);
    chk_alu("jalr.wb", 4'b0001, 1'b1);

    // LUI
    fetch_decode("lui", 7'b0110111, 3'b000);
    step();
    check("lui.exec.alu_cmd", 32'(alu_cmd), 32'd4);
    step();
    chk_ctl("lui.wb", 6'b000011, 2'b00, 2'b11);

    // JAL
    fetch_decode("jal", 7'b1101111, 3'b000);
    step();
    check("jal.exec.alu_cmd", 32'(alu_cmd), 32'd5);
    step();
    chk_ctl("jal.wb", 6'b000011, 2'b01, 2'b10);

    // STORE with same-cycle data ack: PC update in MEM, four cycles total.
    fetch_decode("st", 7'b0100011, 3'b011);
    step();
    chk_alu("st.exec", 4'b0010, 1'b1);
    step();
    d_mem_ack = 1'b1;
    settle();
    chk_ctl("st.mem", 6'b011010, 2'b00, 2'b00);

    // Reset coinciding with an instruction ack: no IR write, req drops after the edge.
    step();
    d_mem_ack = 1'b0;
    rst_n     = 1'b0;
    settle();
    chk_ctl("rst_ack.fetch", 6'b100000, 2'b00, 2'b00);
    step();
    chk_idle("rst_ack.rst", 1'b0);

    // Watchdog: ack never arrives, 16 request cycles then FAULT.
    rst_n     = 1'b1;
    i_mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_ctl($sformatf("wd.wait%0d", i), 6'b100000, 2'b00, 2'b00);
    end
    step();
    chk_idle("wd.fault", 1'b1);
    i_mem_ack = 1'b1;
    step();
    chk_idle("wd.fault_hold", 1'b1);
    rst_n = 1'b0;
    step();
    chk_idle("wd.rst", 1'b0);
    rst_n  = 1'b1;
    opcode = 7'b0110011;
    step();
    chk_ctl("wd.refetch", 6'b100100, 2'b00, 2'b00);
    step();
    chk_ctl("wd.decode", 6'b000000, 2'b00, 2'b00);
    step();
    chk_ctl("wd.exec", 6'b000000, 2'b00, 2'b00);
    step();
    chk_ctl("wd.wb", 6'b000011, 2'b00, 2'b00);

    // Unknown opcode.
    fetch_decode("ill", 7'b1111111, 3'b000);
    step();
`ifdef UC_ILLEGAL_TRAP_EN
    chk_ctl("ill.exec", 6'b000000, 2'b00, 2'b00);
    step();
    chk_idle("ill.fault", 1'b1);
    check("ill.illegal", 32'(illegal), 32'd1);
    rst_n = 1'b0;
    step();
    chk_idle("ill.rst", 1'b0);
    check("ill.illegal_clr", 32'(illegal), 32'd0);
    rst_n = 1'b1;
`else
    chk_ctl("ill.exec", 6'b000010, 2'b00, 2'b00);
    step();
    chk_ctl("ill.next_fetch", 6'b100100, 2'b00, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
